// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/response bundle for the bit-serial adder/subtractor.
//   master : drives start, mode, a, b; observes busy, done, result, carry_out, overflow
//   slave  : the serial_addsub core
//   start     - request pulse, sampled only while the core is idle
//   mode      - 0 = a+b, 1 = a-b (sampled with start)
//   a, b      - WIDTH-bit operands (sampled with start)
//   busy      - high while an operation is shifting or completing
//   done      - one-cycle strobe, result and flags valid
//   result    - sum/difference modulo 2^WIDTH
//   carry_out - unsigned carry (add) / no-borrow (sub)
//   overflow  - signed two's-complement overflow
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor using one full-adder cell and a
// carry flip-flop. Operands are consumed LSB-first, one bit per clock; the
// parallel result is assembled in a right-shifting register.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - serial_addsub_if slave port (start/mode/a/b in,
//           busy/done/result/carry_out/overflow out)
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;
    logic             w_sum;
    logic             w_cy;

    // Single full-adder cell working on the current LSBs.
    assign w_sum = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cy  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert b here and seed carry with mode.
                        r_a     <= bus.a;
                        r_b     <= bus.mode ? ~bus.b : bus.b;
                        r_carry <= bus.mode;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cy;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        // MSB step: overflow is carry-into-MSB xor carry-out-of-MSB.
                        r_ovf  <= r_carry ^ w_cy;
                        r_cout <= w_cy;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.result    = r_res;
    assign bus.carry_out = r_cout;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, scramble the operands right after acceptance,
    // and measure edges-to-done and busy cycles.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                          input logic [7:0] er, input logic ec, input logic eo);
        int lat;
        int bcnt;
        bus.a     = ia;
        bus.b     = ib;
        bus.mode  = im;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = ~ia;
        bus.b     = ib ^ 8'h5A;
        bus.mode  = ~im;
        lat  = 0;
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy) bcnt++;
            if (bus.done) break;
            tick();
            lat++;
        end
        chk("latency", lat, W);
        chk("result", bus.result, er);
        chk("carry_out", bus.carry_out, ec);
        chk("overflow", bus.overflow, eo);
        tick();
        chk("done_one_cycle", bus.done, 1'b0);
        chk("busy_cycles", bcnt, W + 1);
        chk("busy_low_after", bus.busy, 1'b0);
        chk("result_hold", bus.result, er);
    endtask

    initial begin
        int nd;
        int dt[2];
        logic [7:0] dr[2];
        logic dc[2];
        logic dov[2];
        logic [7:0] cap;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[9] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, 8'h00);
        chk("rst_carry", bus.carry_out, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].res, vecs[i].cout, vecs[i].ovf);
            tick();
        end

        // Start pulsed during SHIFT must be ignored.
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nd  = 0;
        cap = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'h11;
                bus.b     = 8'h22;
                bus.mode  = 1'b1;
            end
            if (k == 4) bus.start = 1'b0;
            tick();
            if (bus.done) begin
                nd++;
                cap = bus.result;
            end
        end
        chk("busy_start_ndone", nd, 1);
        chk("busy_start_result", cap, 8'h08);
        chk("busy_start_hold", bus.result, 8'h08);

        // Asynchronous reset part-way through SHIFT.
        bus.a     = 8'h5A;
        bus.b     = 8'h0F;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_result", bus.result, 8'h00);
        chk("arst_carry", bus.carry_out, 1'b0);
        chk("arst_ovf", bus.overflow, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        tick();

        // start held high: the second op is accepted on the first edge spent
        // in IDLE, so done strobes land WIDTH+2 edges apart.
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.a    = 8'hAA;
        bus.b    = 8'h55;
        bus.mode = 1'b1;
        nd = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 10) bus.start = 1'b0;
            if (c == 9) chk("b2b_hold", bus.result, 8'h02);
            if (bus.done && nd < 2) begin
                dt[nd]  = c;
                dr[nd]  = bus.result;
                dc[nd]  = bus.carry_out;
                dov[nd] = bus.overflow;
                nd++;
            end
        end
        chk("b2b_ndone", nd, 2);
        if (nd == 2) begin
            chk("b2b_first_at", dt[0], W);
            chk("b2b_spacing", dt[1] - dt[0], W + 2);
            chk("b2b_res0", dr[0], 8'h02);
            chk("b2b_cout0", dc[0], 1'b0);
            chk("b2b_res1", dr[1], 8'h55);
            chk("b2b_cout1", dc[1], 1'b1);
            chk("b2b_ovf1", dov[1], 1'b1);
        end
        chk("b2b_final_hold", bus.result, 8'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
